// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO push/pop arbiter: parameter defaults, op-state
// and priority encodings, and an index-width helper.
package fifo_arb_pkg;

    localparam int FA_WIDTH = 8;
    localparam int FA_NREQ  = 4;
    localparam int FA_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } op_e;

    typedef enum logic {
        PRIO_PUSH = 1'b0,
        PRIO_POP  = 1'b1
    } prio_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_arbiter.sv
// Round-robin picker: first eligible requester at or above the pointer,
// wrapping modulo NREQ.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = FA_NREQ,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_sel,
    output logic [IW-1:0]   o_idx
);

    localparam int unsigned NREQ_U = NREQ;

    logic          w_found;
    logic [IW-1:0] w_pos;

    always_comb begin
        o_sel   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            w_pos = IW'((32'(i_ptr) + k) % NREQ_U);
            if (!w_found && i_elig[w_pos]) begin
                o_sel[w_pos] = 1'b1;
                o_idx        = w_pos;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arb.sv
// Arbitrates NREQ push requesters and one pop consumer onto a single external
// FIFO, keeping its own occupancy count so pushes and pops never overrun it.
module fifo_arb
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH = FA_WIDTH,
    parameter  int NREQ  = FA_NREQ,
    parameter  int DEPTH = FA_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  fifo_push,
    output logic                  fifo_pop,
    output logic [WIDTH-1:0]      fifo_din,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic [CW-1:0]         count,
    output logic                  err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    op_e             r_op;
    op_e             w_op_nxt;
    prio_e           r_prio;
    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [WIDTH-1:0] r_din;
    logic            r_rd_valid;
    logic [CW-1:0]   r_count;
    logic            r_err;

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_sel;
    logic [IW-1:0]   w_idx;
    logic [WIDTH-1:0] w_din_sel;
    logic [CW-1:0]   w_count_eff;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign w_elig = req & ~r_gnt;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_sel  (w_sel),
        .o_idx  (w_idx)
    );

    always_comb begin
        w_din_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_sel[i]) w_din_sel = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Eligibility uses the count including the op in flight this cycle, so a
    // back-to-back push at DEPTH-1 cannot overrun the FIFO.
    always_comb begin
        w_count_eff = r_count;
        if (r_op == PUSH && r_count != DEPTH_C)
            w_count_eff = r_count + 1'b1;
        else if (r_op == POP && r_count != '0)
            w_count_eff = r_count - 1'b1;
    end

    assign w_push_ok = (|w_elig) && (w_count_eff < DEPTH_C);
    assign w_pop_ok  = rd_req && (r_op != POP) && !r_rd_valid && (w_count_eff != '0);

    always_comb begin
        w_op_nxt = IDLE;
        if (w_push_ok && w_pop_ok)
            w_op_nxt = (r_prio == PRIO_PUSH) ? PUSH : POP;
        else if (w_push_ok)
            w_op_nxt = PUSH;
        else if (w_pop_ok)
            w_op_nxt = POP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= IDLE;
            r_prio     <= PRIO_PUSH;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_din      <= '0;
            r_rd_valid <= 1'b0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_op       <= w_op_nxt;
            r_count    <= w_count_eff;
            r_rd_valid <= (r_op == POP);
            r_gnt      <= '0;
            if (w_push_ok && w_pop_ok)
                r_prio <= (r_prio == PRIO_PUSH) ? PRIO_POP : PRIO_PUSH;
            if (w_op_nxt == PUSH) begin
                r_gnt <= w_sel;
                r_din <= w_din_sel;
                r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
            // FIFO flags are only trusted when nothing is in flight
            if (r_op == IDLE &&
                ((fifo_full && r_count == '0) || (fifo_empty && r_count == DEPTH_C)))
                r_err <= 1'b1;
        end
    end

    assign gnt       = r_gnt;
    assign fifo_push = (r_op == PUSH);
    assign fifo_pop  = (r_op == POP);
    assign fifo_din  = r_din;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = fifo_dout;
    assign count     = r_count;
    assign err       = r_err;

endmodule

// File: tb/tb_fifo_arb.sv
// Directed bench for fifo_arb with a small behavioural FIFO attached.
module tb_fifo_arb;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        rd_req;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_din;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  count;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_arb #(.WIDTH(8), .NREQ(4), .DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .rd_req     (rd_req),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_push  (fifo_push),
        .fifo_pop   (fifo_pop),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .count      (count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External FIFO model, reset together with the arbiter
    logic [7:0] f_mem [8];
    logic [2:0] f_wr;
    logic [2:0] f_rd;
    logic [3:0] f_occ;
    logic       inj_full;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_wr      <= '0;
            f_rd      <= '0;
            f_occ     <= '0;
            fifo_dout <= '0;
        end else begin
            if (fifo_push && f_occ < 4'd8) begin
                f_mem[f_wr] <= fifo_din;
                f_wr        <= f_wr + 3'd1;
            end
            if (fifo_pop && f_occ > 4'd0) begin
                fifo_dout <= f_mem[f_rd];
                f_rd      <= f_rd + 3'd1;
            end
            f_occ <= f_occ + ((fifo_push && f_occ < 4'd8) ? 4'd1 : 4'd0)
                           - ((fifo_pop && f_occ > 4'd0) ? 4'd1 : 4'd0);
        end
    end

    assign fifo_full  = (f_occ == 4'd8) | inj_full;
    assign fifo_empty = (f_occ == 4'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'h0);
        chk({tag, "_push"},  32'(fifo_push), 32'h0);
        chk({tag, "_pop"},   32'(fifo_pop), 32'h0);
        chk({tag, "_din"},   32'(fifo_din), 32'h0);
        chk({tag, "_rdv"},   32'(rd_valid), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_err"},   32'(err), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        rd_req  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [3:0] exp_rr   [5];
    logic [7:0] exp_ord  [3];
    logic [1:0] exp_ops  [12];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ngnt;
        int got;
        int last_pop;

        exp_rr  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        exp_ord = '{8'h11, 8'h22, 8'h33};
        exp_ops = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10,
                    2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01};

        reset_n  = 1'b1;
        req      = '0;
        req_data = '0;
        rd_req   = 1'b0;
        inj_full = 1'b0;

        // Asynchronous clear before any clock edge
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Round-robin with all four held
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req      = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_gnt",  32'(gnt), 32'(exp_rr[i]));
            chk("rr_push", 32'(fifo_push), 32'h1);
        end
        req = '0;
        @(negedge clk);
        chk("rr_count", 32'(count), 32'd5);
        chk("rr_idle",  32'(fifo_push), 32'h0);

        // Single requester
        do_reset();
        req_data = 32'h005A_0000;
        req      = 4'b0100;
        @(negedge clk);
        chk("one_gnt",   32'(gnt), 32'h4);
        chk("one_push",  32'(fifo_push), 32'h1);
        chk("one_din",   32'(fifo_din), 32'h5A);
        chk("one_cnt0",  32'(count), 32'h0);
        req = '0;
        @(negedge clk);
        chk("one_count", 32'(count), 32'h1);
        chk("one_gnt0",  32'(gnt), 32'h0);

        // Ordering: push 11, 22, 33 then pop three
        do_reset();
        req_data = {8'h00, 8'h33, 8'h22, 8'h11};
        req      = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ord_gnt", 32'(gnt), 32'(4'h1 << i));
            chk("ord_din", 32'(fifo_din), 32'(exp_ord[i]));
            req = req & ~gnt;
        end
        @(negedge clk);
        chk("ord_count3", 32'(count), 32'd3);
        rd_req = 1'b1;
        for (int w = 0; w < 3; w++) begin
            got = 0;
            for (int c = 0; c < 8 && got == 0; c++) begin
                @(negedge clk);
                if (rd_valid) got = 1;
            end
            chk("ord_valid", 32'(got), 32'h1);
            chk("ord_data",  32'(rd_data), 32'(exp_ord[w]));
        end
        rd_req = 1'b0;
        chk("ord_count0", 32'(count), 32'h0);

        // Sticky err on inconsistent FIFO flag
        do_reset();
        chk("err_clear", 32'(err), 32'h0);
        inj_full = 1'b1;
        @(negedge clk);
        chk("err_set", 32'(err), 32'h1);
        inj_full = 1'b0;
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'h1);

        // Fill to DEPTH, ninth request waits until one pop
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req      = 4'hF;
        ngnt     = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gnt != '0) ngnt++;
            chk("fill_onehot", 32'($onehot0(gnt)), 32'h1);
        end
        chk("fill_grants", 32'(ngnt), 32'd8);
        chk("fill_count",  32'(count), 32'd8);
        rd_req = 1'b1;
        ngnt   = 0;
        got    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (gnt != '0) ngnt++;
            if (rd_valid) begin
                got++;
                chk("fill_rdata", 32'(rd_data), 32'hA0);
                rd_req = 1'b0;
            end
        end
        chk("fill_pops",    32'(got), 32'd1);
        chk("fill_regrant", 32'(ngnt), 32'd1);
        chk("fill_count8",  32'(count), 32'd8);
        req = '0;

        // Contention at count=4
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req      = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = req & ~gnt;
        end
        @(negedge clk);
        chk("cont_count4", 32'(count), 32'd4);
        req      = 4'b0001;
        rd_req   = 1'b1;
        last_pop = -100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("cont_op",   32'({fifo_push, fifo_pop}), 32'(exp_ops[i]));
            chk("cont_excl", 32'(fifo_push & fifo_pop), 32'h0);
            if (fifo_pop) begin
                if (last_pop >= 0) chk("cont_pop_gap", 32'((i - last_pop) >= 3), 32'h1);
                last_pop = i;
            end
        end

        // Reset while a grant is on the outputs
        req    = 4'b0110;
        rd_req = 1'b0;
        got    = 0;
        for (int c = 0; c < 6 && got == 0; c++) begin
            @(negedge clk);
            if (gnt != '0) got = 1;
        end
        chk("midrst_gnt_seen", 32'(got), 32'h1);
        reset_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_regnt", 32'(gnt), 32'h2);
        chk("midrst_push",  32'(fifo_push), 32'h1);
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
